// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the data-memory access stage.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_WAIT_GNT    = 2'd1,
    S_WAIT_RVALID = 2'd2,
    S_DONE        = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_load_format.sv
// Picks the addressed byte/halfword out of a loaded word and extends it per funct3.
module mem_load_format
  import mem_pkg::*;
(
  input  logic [31:0] load_q_i,
  input  logic [1:0]  a_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = load_q_i[{a_i, 3'b000} +: 8];
    h = a_i[1] ? load_q_i[31:16] : load_q_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{b[7]}}, b};
      F3_LH:   data_o = {{16{h[15]}}, h};
      F3_LW:   data_o = load_q_i;
      F3_LBU:  data_o = {24'd0, b};
      F3_LHU:  data_o = {16'd0, h};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: req/gnt/rvalid data-memory FSM, byte-lane generation and load formatting.
// MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of masking the low address bits.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EXMEM_valid,
  input  logic              EXMEM_MemRead,
  input  logic              EXMEM_MemWrite,
  input  logic [2:0]        EXMEM_Funct3,
  input  logic [31:0]       EXMEM_AluRES,
  input  logic [31:0]       EXMEM_StoreData,
  output logic [31:0]       MEM_LoadData,
  output logic              MEM_Stall,
  output logic              MEM_Misalign,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata
);

  mem_state_t  state_q;
  logic [31:0] load_q;
  logic [31:0] fmt;
  logic        mem_op, is_store, is_load, misalign, issue;
  logic [1:0]  a, a_eff, sz;

  assign mem_op   = EXMEM_valid & (EXMEM_MemRead | EXMEM_MemWrite);
  assign is_store = EXMEM_MemWrite;
  assign is_load  = EXMEM_MemRead & ~EXMEM_MemWrite;
  assign sz       = EXMEM_Funct3[1:0];
  assign a        = EXMEM_AluRES[1:0];

  // Natural alignment: halfwords drop a[0], words drop a[1:0].
  always_comb begin
    case (sz)
      2'b01:   a_eff = {a[1], 1'b0};
      2'b10:   a_eff = 2'b00;
      default: a_eff = a;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = mem_op & ((sz == 2'b01 & a[0]) | (sz == 2'b10 & (a != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  // Outputs are gated by rst_n so a reset drops the bus immediately.
  assign issue = rst_n & mem_op & ~misalign &
                 ((state_q == S_IDLE) | (state_q == S_WAIT_GNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      load_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_WAIT_GNT: begin
          if (!issue)        state_q <= S_IDLE;
          else if (!dmem_gnt) state_q <= S_WAIT_GNT;
          else if (is_load)   state_q <= S_WAIT_RVALID;
          else                state_q <= S_DONE;
        end
        S_WAIT_RVALID: begin
          if (dmem_rvalid) begin
            load_q  <= dmem_rdata;
            state_q <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  mem_load_format u_fmt (
    .load_q_i (load_q),
    .a_i      (a_eff),
    .funct3_i (EXMEM_Funct3),
    .data_o   (fmt)
  );

  assign dmem_req     = issue;
  assign dmem_we      = issue & is_store;
  assign dmem_addr    = issue ? {EXMEM_AluRES[ADDR_W-1:2], 2'b00} : '0;
  assign MEM_Stall    = issue | (rst_n & (state_q == S_WAIT_RVALID));
  assign MEM_Misalign = rst_n & (state_q == S_IDLE) & misalign;
  assign MEM_LoadData = (rst_n & (state_q == S_DONE) & is_load) ? fmt : '0;

  always_comb begin
    dmem_be    = '0;
    dmem_wdata = '0;
    if (issue) begin
      if (!is_store) begin
        dmem_be = 4'hF;
      end else begin
        case (EXMEM_Funct3)
          F3_SB: begin
            dmem_be    = 4'b0001 << a_eff;
            dmem_wdata = {4{EXMEM_StoreData[7:0]}};
          end
          F3_SH: begin
            dmem_be    = a_eff[1] ? 4'b1100 : 4'b0011;
            dmem_wdata = {2{EXMEM_StoreData[15:0]}};
          end
          F3_SW: begin
            dmem_be    = 4'hF;
            dmem_wdata = EXMEM_StoreData;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against an arithmetic reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        EXMEM_valid, EXMEM_MemRead, EXMEM_MemWrite;
  logic [2:0]  EXMEM_Funct3;
  logic [31:0] EXMEM_AluRES, EXMEM_StoreData;
  logic [31:0] MEM_LoadData;
  logic        MEM_Stall, MEM_Misalign;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_chk = 0;
  int n_fail = 0;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .EXMEM_valid(EXMEM_valid), .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .EXMEM_Funct3(EXMEM_Funct3), .EXMEM_AluRES(EXMEM_AluRES), .EXMEM_StoreData(EXMEM_StoreData),
    .MEM_LoadData(MEM_LoadData), .MEM_Stall(MEM_Stall), .MEM_Misalign(MEM_Misalign),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  // Access size in bytes from funct3 (0 = undefined).
  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic int eff_off(input logic [31:0] addr, input logic [2:0] f3);
    int sz = size_of(f3);
    int off = int'(addr % 4);
    if (sz == 0) return off;
    return off - (off % sz);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int off = eff_off(addr, f3);
    longint unsigned v;
    case (f3)
      3'b000: begin v = (rdata >> (8*off)) % 256;   if (v >= 128)   v = v + 64'hFFFFFF00; end
      3'b001: begin v = (rdata >> (8*off)) % 65536; if (v >= 32768) v = v + 64'hFFFF0000; end
      3'b010: v = rdata;
      3'b100: v = (rdata >> (8*off)) % 256;
      3'b101: v = (rdata >> (8*off)) % 65536;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] model_be(input bit st, input logic [31:0] addr, input logic [2:0] f3);
    int off = eff_off(addr, f3);
    if (!st) return 4'hF;
    case (f3)
      3'b000: return 4'(1 << off);
      3'b001: return (off == 2) ? 4'hC : 4'h3;
      3'b010: return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(input logic [31:0] sd, input logic [2:0] f3);
    case (f3)
      3'b000: return (sd % 256) * 32'h0101_0101;
      3'b001: return (sd % 65536) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  task automatic idle();
    EXMEM_valid = 0; EXMEM_MemRead = 0; EXMEM_MemWrite = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = '0;
  endtask

  // Drives one memory instruction to completion; caller is at posedge+1.
  task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [31:0] rdata, input int gd, input int rdl,
                        input string nm);
    bit st = wr;
    int stalls = 0;
    int exp_st = st ? gd + 1 : gd + rdl + 2;
    logic [31:0] exp_ld = st ? 32'h0 : model_load(rdata, addr, f3);
    logic [3:0]  exp_be = model_be(st, addr, f3);
    EXMEM_valid = 1; EXMEM_MemRead = rd; EXMEM_MemWrite = wr;
    EXMEM_Funct3 = f3; EXMEM_AluRES = addr; EXMEM_StoreData = sd;
    for (int i = 0; i <= gd; i++) begin
      dmem_gnt = (i == gd);
      dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
      @(negedge clk);
      n_chk++;
      if (dmem_req !== 1'b1 || dmem_we !== st || dmem_addr !== (addr & 32'hFFFF_FFFC) ||
          dmem_be !== exp_be || MEM_Misalign !== 1'b0) begin
        n_fail++;
        $display("FAIL %s req-phase cyc%0d: req=%b we=%b addr=%h be=%b mis=%b, want req=1 we=%b addr=%h be=%b mis=0",
                 nm, i, dmem_req, dmem_we, dmem_addr, dmem_be, MEM_Misalign, st, addr & 32'hFFFF_FFFC, exp_be);
      end
      if (st) begin
        n_chk++;
        if (dmem_wdata !== model_wd(sd, f3)) begin
          n_fail++;
          $display("FAIL %s wdata: got %h want %h", nm, dmem_wdata, model_wd(sd, f3));
        end
      end
      if (MEM_Stall === 1'b1) stalls++;
      @(posedge clk); #1;
    end
    dmem_gnt = 0;
    if (!st) begin
      for (int i = 0; i <= rdl; i++) begin
        dmem_rvalid = (i == rdl);
        dmem_rdata = (i == rdl) ? rdata : $urandom;
        @(negedge clk);
        n_chk++;
        if (dmem_req !== 1'b0 || MEM_LoadData !== 32'h0) begin
          n_fail++;
          $display("FAIL %s rvalid-wait cyc%0d: req=%b ld=%h, want req=0 ld=0", nm, i, dmem_req, MEM_LoadData);
        end
        if (MEM_Stall === 1'b1) stalls++;
        @(posedge clk); #1;
      end
    end
    dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
    @(negedge clk);
    n_chk++;
    if (MEM_Stall !== 1'b0 || dmem_req !== 1'b0 || MEM_LoadData !== exp_ld) begin
      n_fail++;
      $display("FAIL %s done: stall=%b req=%b ld=%h, want stall=0 req=0 ld=%h", nm, MEM_Stall, dmem_req, MEM_LoadData, exp_ld);
    end
    n_chk++;
    if (stalls != exp_st) begin
      n_fail++;
      $display("FAIL %s stall count: got %0d want %0d", nm, stalls, exp_st);
    end
    @(posedge clk); #1;
    dmem_rvalid = 0;
  endtask

  task automatic check_quiet(input string nm);
    n_chk++;
    if (dmem_req !== 0 || MEM_Stall !== 0 || MEM_LoadData !== 0 || dmem_we !== 0 ||
        dmem_addr !== 0 || dmem_be !== 0 || dmem_wdata !== 0 || MEM_Misalign !== 0) begin
      n_fail++;
      $display("FAIL %s: req=%b stall=%b ld=%h we=%b addr=%h be=%b wd=%h mis=%b, want all 0",
               nm, dmem_req, MEM_Stall, MEM_LoadData, dmem_we, dmem_addr, dmem_be, dmem_wdata, MEM_Misalign);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    EXMEM_Funct3 = 3'b010; EXMEM_AluRES = 32'h100; EXMEM_StoreData = 32'h1234;
    EXMEM_valid = 1; EXMEM_MemRead = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_quiet("reset_outputs");
    idle();
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    check_quiet("post_reset_idle");
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, "lw_0x100");
    idle(); @(posedge clk); #1;
    run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, "lb_0x103");
    run_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 0, 1, "lbu_0x103");
    run_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 1, 0, "lhu_0x102");
    run_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 0, 0, "lh_0x102");
    run_op(0, 1, 3'b000, 32'h201, 32'h1234_5678, 32'h0, 3, 0, "sb_0x201_gnt3");
    run_op(0, 1, 3'b001, 32'h202, 32'hCAFE_BABE, 32'h0, 0, 0, "sh_0x202");
    run_op(1, 1, 3'b010, 32'h204, 32'hA5A5_5A5A, 32'h0, 1, 0, "rw_both_is_store");
    run_op(1, 0, 3'b011, 32'h208, 32'h0, 32'hFFFF_FFFF, 0, 2, "load_undef_f3");
    idle(); @(posedge clk); #1;
  endtask

  task automatic test_nonmem();
    EXMEM_valid = 1; EXMEM_MemRead = 0; EXMEM_MemWrite = 0;
    EXMEM_Funct3 = 3'b010; EXMEM_AluRES = 32'h300;
    dmem_rvalid = 1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    check_quiet("nonmem");
    @(posedge clk); #1;
    @(negedge clk);
    check_quiet("nonmem_rvalid_ignored");
    @(posedge clk); #1;
    idle(); @(posedge clk); #1;
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    EXMEM_valid = 1; EXMEM_MemRead = 1; EXMEM_MemWrite = 0;
    EXMEM_Funct3 = 3'b010; EXMEM_AluRES = 32'h102;
    dmem_gnt = 1;
    @(negedge clk);
    n_chk++;
    if (MEM_Misalign !== 1 || dmem_req !== 0 || MEM_Stall !== 0 || MEM_LoadData !== 0) begin
      n_fail++;
      $display("FAIL misalign_lw: mis=%b req=%b stall=%b ld=%h, want 1 0 0 0", MEM_Misalign, dmem_req, MEM_Stall, MEM_LoadData);
    end
    @(posedge clk); #1;
    EXMEM_Funct3 = 3'b001; EXMEM_MemRead = 0; EXMEM_MemWrite = 1; EXMEM_AluRES = 32'h105;
    @(negedge clk);
    n_chk++;
    if (MEM_Misalign !== 1 || dmem_req !== 0 || MEM_Stall !== 0) begin
      n_fail++;
      $display("FAIL misalign_sh: mis=%b req=%b stall=%b, want 1 0 0", MEM_Misalign, dmem_req, MEM_Stall);
    end
    @(posedge clk); #1;
    idle();
    run_op(1, 0, 3'b010, 32'h104, 32'h0, 32'h0BAD_F00D, 0, 0, "lw_after_misalign");
`else
    run_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0BAD_F00D, 0, 0, "lw_0x102_masked");
    run_op(0, 1, 3'b001, 32'h203, 32'h0000_BEEF, 32'h0, 1, 0, "sh_0x203_masked");
`endif
    idle(); @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    for (int k = 0; k < 40; k++) begin
      bit wr = 1'($urandom);
      bit rd = wr ? 1'($urandom) : 1'b1;
      logic [2:0] f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      logic [31:0] addr = $urandom;
`ifdef MEM_MISALIGN_TRAP_EN
      addr = addr - (addr % size_of(f3));
`endif
      run_op(rd, wr, f3, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "random");
      if ($urandom_range(0, 1) == 0) begin idle(); @(posedge clk); #1; end
    end
    idle(); @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    run_op(0, 1, 3'b010, 32'h400, 32'h0102_0304, 32'h0, 0, 0, "b2b_sw");
    run_op(1, 0, 3'b000, 32'h401, 32'h0, 32'h0000_F100, 0, 0, "b2b_lb");
    run_op(1, 0, 3'b010, 32'h408, 32'h0, 32'h7777_8888, 2, 1, "b2b_lw");
    idle(); @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    EXMEM_valid = 1; EXMEM_MemRead = 1; EXMEM_MemWrite = 0;
    EXMEM_Funct3 = 3'b010; EXMEM_AluRES = 32'h500;
    dmem_gnt = 1;
    @(posedge clk); #1;
    dmem_gnt = 0;
    @(negedge clk);
    n_chk++;
    if (MEM_Stall !== 1 || dmem_req !== 0) begin
      n_fail++;
      $display("FAIL reset_mid pre: stall=%b req=%b, want 1 0", MEM_Stall, dmem_req);
    end
    #2 rst_n = 0;
    #1 check_quiet("reset_mid_async");
    @(posedge clk); #1;
    idle();
    rst_n = 1;
    dmem_rvalid = 1; dmem_rdata = 32'h55;
    @(negedge clk);
    check_quiet("reset_mid_late_rvalid");
    @(posedge clk); #1;
    dmem_rvalid = 0;
    n_chk++;
    if (dut.load_q !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid load_q: got %h want 00000000", dut.load_q);
    end
  endtask

  initial begin
    EXMEM_Funct3 = '0; EXMEM_AluRES = '0; EXMEM_StoreData = '0;
    test_reset();
    test_directed();
    test_nonmem();
    test_misalign();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
